// File: rtl/recv_pkg.sv
// Shared types and constants for the serial word receiver.
package recv_pkg;

    // Byte-level receive FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Bytes assembled into one output word, LSB byte first.
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, falling-edge start detection,
// mid-bit sampling, registered byte_done / frame_err pulses.
module uart_rx_byte
    import recv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_done_o,
    output logic       frame_err_o,
    output logic       idle_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic [1:0]    sync_vld_q;
    logic          rxs;
    logic          rxs_prev_q, rxs_prev_d;
    logic          fall;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    byte_sr_q, byte_sr_d;
    logic          byte_done_q, byte_done_d;
    logic          frame_err_q, frame_err_d;

    assign rxs = sync_q[1];
    // The edge register only tracks real line samples, so the synchronizer's
    // reset value of 1 can never pair with a low line into a fake start edge.
    assign rxs_prev_d = sync_vld_q[1] ? rxs : 1'b0;
    assign fall       = rxs_prev_q & ~rxs;

    // Synchronizer, edge register and all FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            sync_vld_q  <= 2'b00;
            rxs_prev_q  <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            byte_sr_q   <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rxd_i};
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            rxs_prev_q  <= rxs_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_sr_q   <= byte_sr_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: half-bit start confirm, then full-bit sample spacing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        byte_sr_d   = byte_sr_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d   = START;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    byte_sr_d = {rxs, byte_sr_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign byte_o      = byte_sr_q;
    assign byte_done_o = byte_done_q;
    assign frame_err_o = frame_err_q;
    assign idle_o      = (state_q == IDLE);

endmodule

// File: rtl/recv_word.sv
// Serial word receiver: collects four bytes (LSB byte first) into a 32-bit
// word, drops partial words on framing errors or inter-byte timeout.
module recv_word
    import recv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        frame_err,
    output logic        timeout_err
);

    localparam int TMAX = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TMAX_M1  = TW'(TMAX - 1);
    localparam logic [1:0]    LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [7:0]    rx_byte;
    logic          rx_byte_done;
    logic          rx_frame_err;
    logic          rx_idle;

    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   partial_q, partial_d;
    logic [31:0]   word_q, word_d;
    logic          word_valid_q, word_valid_d;
    logic          timeout_err_q, timeout_err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd_i      (rxd),
        .byte_o     (rx_byte),
        .byte_done_o(rx_byte_done),
        .frame_err_o(rx_frame_err),
        .idle_o     (rx_idle)
    );

    // Word assembler and timeout state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_q    <= '0;
            partial_q     <= '0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            byte_idx_q    <= byte_idx_d;
            partial_q     <= partial_d;
            word_q        <= word_d;
            word_valid_q  <= word_valid_d;
            timeout_err_q <= timeout_err_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    // Byte placement, word completion and inter-byte timeout.
    always_comb begin
        byte_idx_d    = byte_idx_q;
        partial_d     = partial_q;
        word_d        = word_q;
        word_valid_d  = 1'b0;
        timeout_err_d = 1'b0;
        to_cnt_d      = to_cnt_q;

        // Idle time is only counted between bytes of a started word.
        if (byte_idx_q == 2'd0 || rx_byte_done) begin
            to_cnt_d = '0;
        end else if (rx_idle) begin
            if (to_cnt_q == TMAX_M1) begin
                to_cnt_d      = '0;
                timeout_err_d = 1'b1;
                byte_idx_d    = 2'd0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        if (rx_frame_err) begin
            byte_idx_d = 2'd0;
        end else if (rx_byte_done) begin
            if (byte_idx_q == LAST_IDX) begin
                word_d       = {rx_byte, partial_q};
                word_valid_d = 1'b1;
                byte_idx_d   = 2'd0;
            end else begin
                for (int b = 0; b < BYTES_PER_WORD - 1; b++) begin
                    if (byte_idx_q == 2'(b)) begin
                        partial_d[b*8 +: 8] = rx_byte;
                    end
                end
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end
    end

    assign word        = word_q;
    assign word_valid  = word_valid_q;
    assign frame_err   = rx_frame_err;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_recv_word.sv
// Bench for recv_word: directed scenarios plus randomized byte streams,
// checked against a byte-list reference model of the word assembler.
module tb_recv_word;

    localparam int CPB = 8;
    localparam int TOB = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [31:0] word;
    logic        word_valid;
    logic        frame_err;
    logic        timeout_err;

    always #5 clk = ~clk;

    recv_word #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .word       (word),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .timeout_err(timeout_err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int unsigned byte_start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observations taken mid-cycle.
    logic [31:0] obs_words[$];
    int unsigned obs_wv_cyc[$];
    int          n_fe = 0;
    int          n_to = 0;
    int unsigned last_to_cyc = 0;

    always @(negedge clk) begin
        if (word_valid) begin
            obs_words.push_back(word);
            obs_wv_cyc.push_back(cyc);
        end
        if (frame_err)   n_fe <= n_fe + 1;
        if (timeout_err) begin
            n_to        <= n_to + 1;
            last_to_cyc <= cyc;
        end
    end

    // Reference model: list of received bytes grouped four at a time.
    logic [7:0]  m_part[4];
    int          m_idx = 0;
    logic [31:0] m_word = '0;
    logic [31:0] exp_words[$];
    int          exp_fe = 0;
    int          exp_to = 0;

    function automatic void model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_idx = 0;
            exp_fe++;
        end else begin
            m_part[m_idx] = b;
            m_idx++;
            if (m_idx == 4) begin
                m_word = {m_part[3], m_part[2], m_part[1], m_part[0]};
                exp_words.push_back(m_word);
                m_idx = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input bit v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        byte_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(ok);
        model_byte(b, ok);
        $display("tx byte %02h stop=%0d", b, ok);
        if (!ok) idle(2 * CPB);
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, obs_words.size(), exp_words.size());
        while (obs_words.size() > 0 && exp_words.size() > 0)
            chk({tag, "_word"}, obs_words.pop_front(), exp_words.pop_front());
        obs_words.delete();
        exp_words.delete();
        obs_wv_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  s1_bytes[4];
        int unsigned s_ref;
        int          d;
        logic [7:0]  b;
        bit          ok;

        s1_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word", word, 32'h0);
        chk("rst_flags", {29'd0, word_valid, frame_err, timeout_err}, 32'h0);
        rst = 1'b0;
        idle(20);

        // Back-to-back word with latency check on word_valid.
        s_ref = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) s_ref = cyc;
            send_byte(s1_bytes[i], 1'b1);
        end
        idle(20);
        d = (obs_wv_cyc.size() > 0) ? int'(obs_wv_cyc[0] - s_ref) : -1;
        chk("s1_wv_latency", {31'd0, (d >= 78 && d <= 82)}, 32'd1);
        check_words("s1");
        chk("s1_fe", n_fe, exp_fe);
        chk("s1_to", n_to, exp_to);

        // Short glitch: no byte, no errors.
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(40);
        chk("glitch_words", obs_words.size(), 0);
        chk("glitch_fe", n_fe, exp_fe);
        chk("glitch_to", n_to, exp_to);

        // Framing error then a clean word.
        send_byte(8'hAA, 1'b0);
        chk("s3_fe", n_fe, exp_fe);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        idle(20);
        check_words("s3");
        chk("s3_word", word, 32'h04030201);

        // Inter-byte timeout after two bytes.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        s_ref = byte_start_cyc;
        idle(200);
        m_idx = 0;
        exp_to++;
        chk("s4_to", n_to, exp_to);
        d = int'(last_to_cyc - s_ref);
        chk("s4_to_timing", {31'd0, (d >= 237 && d <= 243)}, 32'd1);
        send_byte(8'hDD, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hAA, 1'b1);
        idle(20);
        check_words("s4");
        chk("s4_word", word, 32'hAABBCCDD);

        // Reset during bit 4 of the second byte; line held low past release.
        send_byte(8'h55, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("s5_rst_word", word, 32'h0);
        chk("s5_rst_flags", {29'd0, word_valid, frame_err, timeout_err}, 32'h0);
        m_idx  = 0;
        m_word = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        idle(40);
        chk("s5_no_spurious", obs_words.size(), 0);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        idle(20);
        check_words("s5");
        chk("s5_word", word, 32'hDEADBEEF);
        chk("s5_fe", n_fe, exp_fe);

        // Two back-to-back words: all zeros, all ones.
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b1);
        idle(20);
        check_words("s6");

        // Randomized bytes, gaps and framing errors.
        for (int i = 0; i < 28; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            send_byte(b, ok);
            idle($urandom_range(0, 40));
        end
        idle(20);
        if (m_idx != 0) begin
            idle(200);
            m_idx = 0;
            exp_to++;
        end
        check_words("rand");
        chk("rand_fe", n_fe, exp_fe);
        chk("rand_to", n_to, exp_to);
        chk("final_word", word, m_word);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
